// File: rtl/sram_serial_loader_arb_pkg.sv
// Shared definitions for the SRAM serial loader / CPU arbiter.
//   state_e       : loader FSM state encoding
//   MODE_*        : CTRL_MODE codes (idle, serial write, serial read, CPU run)
package sram_serial_loader_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShAddr,
        StShData,
        StMemWr,
        StRdReq,
        StRdCap,
        StShOut,
        StDone
    } state_e;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_WR   = 2'b01;
    localparam logic [1:0] MODE_RD   = 2'b10;
    localparam logic [1:0] MODE_CPU  = 2'b11;

endpackage

// File: rtl/sram_serial_loader_arb_port_mux.sv
// Combinational SRAM pin selection between the serial loader and the CPU.
//   gnt_i               : CPU owns the SRAM (registered grant from the top)
//   cpu_cen_i/wen_i/a_i/d_i : CPU strobes, address and write data
//   ldr_cen_i/wen_i/a_i/d_i : loader strobes, address and write data
//   cen_o/wen_o/a_o/d_o     : pins driven to the SRAM macro
module sram_port_mux #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              gnt_i,
    input  logic              cpu_cen_i,
    input  logic              cpu_wen_i,
    input  logic [ADDR_W-1:0] cpu_a_i,
    input  logic [DATA_W-1:0] cpu_d_i,
    input  logic              ldr_cen_i,
    input  logic              ldr_wen_i,
    input  logic [ADDR_W-1:0] ldr_a_i,
    input  logic [DATA_W-1:0] ldr_d_i,
    output logic              cen_o,
    output logic              wen_o,
    output logic [ADDR_W-1:0] a_o,
    output logic [DATA_W-1:0] d_o
);

    // Without the grant, CPU strobes never reach the macro.
    assign cen_o = gnt_i ? cpu_cen_i : ldr_cen_i;
    assign wen_o = gnt_i ? cpu_wen_i : ldr_wen_i;
    assign a_o   = gnt_i ? cpu_a_i   : ldr_a_i;
    assign d_o   = gnt_i ? cpu_d_i   : ldr_d_i;

endmodule

// File: rtl/sram_serial_loader_arb.sv
// SRAM owner: arbitrates a single-port synchronous SRAM between a serial scan
// loader (burst write / burst readback over CTRL_SI / CTRL_SO) and the CPU port.
// Optional build macro SCAN_PARITY_EN: each serial word carries a trailing
// even-parity bit; bad write words are dropped and flagged on PAR_ERR.
// Ports:
//   CLK, RST_N         : clock, asynchronous active-low reset
//   CTRL_MODE          : 00 idle, 01 serial write, 10 serial read, 11 CPU run
//   CTRL_BGN           : rising edge starts a serial burst (from IDLE only)
//   CTRL_SI / CTRL_SO  : serial data in / out, MSB first
//   CTRL_RDY           : loader idle or done
//   CPU_GNT            : CPU owns the SRAM
//   CPU_CEN/WEN/A/D/Q  : CPU SRAM port
//   *_after_mux        : SRAM macro pins; Q_from_SRAM is the macro read data
//   PAR_ERR            : sticky serial parity error
module sram_serial_loader_arb
    import sram_serial_loader_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [1:0]        CTRL_MODE,
    input  logic              CTRL_BGN,
    input  logic              CTRL_SI,
    output logic              CTRL_SO,
    output logic              CTRL_RDY,
    output logic              CPU_GNT,
    input  logic              CPU_CEN,
    input  logic              CPU_WEN,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic [DATA_W-1:0] CPU_D,
    output logic [DATA_W-1:0] CPU_Q,
    output logic              CEN_after_mux,
    output logic              WEN_after_mux,
    output logic [ADDR_W-1:0] A_after_mux,
    output logic [DATA_W-1:0] D_after_mux,
    input  logic [DATA_W-1:0] Q_from_SRAM,
    output logic              PAR_ERR
);

`ifdef SCAN_PARITY_EN
    localparam int unsigned FRAME_W = DATA_W + 1;
`else
    localparam int unsigned FRAME_W = DATA_W;
`endif
    localparam int unsigned BIT_MAX = (ADDR_W > FRAME_W) ? ADDR_W : FRAME_W;
    localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(BURST_LEN + 1);

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic                 bgn_q;
    logic                 gnt_q, gnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [FRAME_W-1:0]   sh_q, sh_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_err_q, par_err_d;

    logic                 start;
    logic                 ldr_cen, ldr_wen;
    logic                 rdy, so;
    logic                 par_ok;
    logic [DATA_W-1:0]    wr_word;
    logic [FRAME_W-1:0]   rd_frame;
    logic [ADDR_W:0]      addr_shift;
    logic [FRAME_W:0]     sh_in, sh_out;
    logic [CNT_W-1:0]     cnt_inc;
    logic [ADDR_W-1:0]    addr_inc;

    // Data bits always sit in the top DATA_W bits of the frame; the parity
    // bit (when present) is the LSB.
    assign wr_word = sh_q[FRAME_W-1 -: DATA_W];

`ifdef SCAN_PARITY_EN
    assign par_ok   = ~(^sh_q);
    assign rd_frame = {Q_from_SRAM, ^Q_from_SRAM};
`else
    assign par_ok   = 1'b1;
    assign rd_frame = Q_from_SRAM;
`endif

    assign start = CTRL_BGN & ~bgn_q & (state_q == StIdle) &
                   ((CTRL_MODE == MODE_WR) | (CTRL_MODE == MODE_RD));

    assign addr_shift = {addr_q, CTRL_SI};
    assign sh_in      = {sh_q, CTRL_SI};
    assign sh_out     = {sh_q, 1'b0};
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign addr_inc   = addr_q + ADDR_W'(1);  // wraps modulo 2**ADDR_W

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        par_err_d = par_err_q;
        ldr_cen   = 1'b1;
        ldr_wen   = 1'b1;
        rdy       = 1'b0;
        so        = 1'b0;
        gnt_d     = (state_q == StIdle) && (CTRL_MODE == MODE_CPU);

        unique case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (start) begin
                    state_d   = StShAddr;
                    mode_d    = CTRL_MODE;
                    bit_d     = '0;
                    cnt_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            StShAddr: begin
                addr_d = addr_shift[ADDR_W-1:0];
                if (bit_q == BIT_W'(ADDR_W - 1)) begin
                    bit_d   = '0;
                    state_d = (mode_q == MODE_RD) ? StRdReq : StShData;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            StShData: begin
                sh_d = sh_in[FRAME_W-1:0];
                if (bit_q == BIT_W'(FRAME_W - 1)) begin
                    bit_d   = '0;
                    state_d = StMemWr;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            StMemWr: begin
                // A bad-parity word is dropped but still consumes its address.
                if (par_ok) begin
                    ldr_cen = 1'b0;
                    ldr_wen = 1'b0;
                end else begin
                    par_err_d = 1'b1;
                end
                addr_d  = addr_inc;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == CNT_W'(BURST_LEN)) ? StDone : StShData;
            end
            StRdReq: begin
                ldr_cen = 1'b0;
                state_d = StRdCap;
            end
            StRdCap: begin
                sh_d    = rd_frame;
                bit_d   = '0;
                state_d = StShOut;
            end
            StShOut: begin
                so   = sh_q[FRAME_W-1];
                sh_d = sh_out[FRAME_W-1:0];
                if (bit_q == BIT_W'(FRAME_W - 1)) begin
                    bit_d   = '0;
                    addr_d  = addr_inc;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_W'(BURST_LEN)) ? StDone : StRdReq;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            StDone: begin
                rdy     = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            mode_q    <= MODE_IDLE;
            bgn_q     <= 1'b0;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            bgn_q     <= CTRL_BGN;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            par_err_q <= par_err_d;
        end
    end

    sram_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_mux (
        .gnt_i     (gnt_q),
        .cpu_cen_i (CPU_CEN),
        .cpu_wen_i (CPU_WEN),
        .cpu_a_i   (CPU_A),
        .cpu_d_i   (CPU_D),
        .ldr_cen_i (ldr_cen),
        .ldr_wen_i (ldr_wen),
        .ldr_a_i   (addr_q),
        .ldr_d_i   (wr_word),
        .cen_o     (CEN_after_mux),
        .wen_o     (WEN_after_mux),
        .a_o       (A_after_mux),
        .d_o       (D_after_mux)
    );

    assign CPU_GNT  = gnt_q;
    assign CPU_Q    = Q_from_SRAM;
    assign CTRL_SO  = so;
    assign CTRL_RDY = rdy;
    assign PAR_ERR  = par_err_q;

endmodule

// File: tb/tb_sram_serial_loader_arb.sv
// Directed bench for sram_serial_loader_arb with a behavioural SRAM model.
module tb_sram_serial_loader_arb;
    import sram_serial_loader_arb_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 9;
    localparam int unsigned BL = 4;

    logic          CLK, RST_N;
    logic [1:0]    CTRL_MODE;
    logic          CTRL_BGN, CTRL_SI, CTRL_SO, CTRL_RDY, CPU_GNT;
    logic          CPU_CEN, CPU_WEN;
    logic [AW-1:0] CPU_A;
    logic [DW-1:0] CPU_D, CPU_Q;
    logic          CEN_after_mux, WEN_after_mux;
    logic [AW-1:0] A_after_mux;
    logic [DW-1:0] D_after_mux, Q_from_SRAM;
    logic          PAR_ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int acc0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] q_mem;

    sram_serial_loader_arb #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BURST_LEN (BL)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .CTRL_MODE     (CTRL_MODE),
        .CTRL_BGN      (CTRL_BGN),
        .CTRL_SI       (CTRL_SI),
        .CTRL_SO       (CTRL_SO),
        .CTRL_RDY      (CTRL_RDY),
        .CPU_GNT       (CPU_GNT),
        .CPU_CEN       (CPU_CEN),
        .CPU_WEN       (CPU_WEN),
        .CPU_A         (CPU_A),
        .CPU_D         (CPU_D),
        .CPU_Q         (CPU_Q),
        .CEN_after_mux (CEN_after_mux),
        .WEN_after_mux (WEN_after_mux),
        .A_after_mux   (A_after_mux),
        .D_after_mux   (D_after_mux),
        .Q_from_SRAM   (Q_from_SRAM),
        .PAR_ERR       (PAR_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous SRAM: read data valid the cycle after the strobe.
    always @(posedge CLK) begin
        if (!CEN_after_mux) begin
            acc_cnt <= acc_cnt + 1;
            if (!WEN_after_mux) mem[A_after_mux] <= D_after_mux;
            else q_mem <= mem[A_after_mux];
        end
    end
    assign Q_from_SRAM = q_mem;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_start(input logic [1:0] mode, input logic [AW-1:0] addr);
        CTRL_MODE = mode;
        CTRL_BGN  = 1'b1;
        tick();
        CTRL_BGN  = 1'b0;
        for (int b = AW - 1; b >= 0; b--) begin
            CTRL_SI = addr[b];
            tick();
        end
    endtask

    // words: word 0 in the top byte; bad[i] flips the parity bit of word i.
    task automatic wr_burst(input logic [AW-1:0] addr, input logic [31:0] words,
                            input logic [3:0] bad, input logic glitch);
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        logic          exp_strobe;
        send_start(MODE_WR, addr);
        if (glitch) CTRL_MODE = MODE_CPU;
        for (int i = 0; i < 4; i++) begin
            w = words[31 - 8*i -: 8];
            a = addr + AW'(i);
            for (int b = DW - 1; b >= 0; b--) begin
                CTRL_SI = w[b];
                tick();
            end
            exp_strobe = 1'b1;
`ifdef SCAN_PARITY_EN
            CTRL_SI = (^w) ^ bad[i];
            tick();
            exp_strobe = ~bad[i];
`endif
            @(negedge CLK);
            check_eq("wr_cen", {31'd0, CEN_after_mux}, {31'd0, ~exp_strobe});
            check_eq("wr_rdy_busy", {31'd0, CTRL_RDY}, 32'd0);
            check_eq("wr_gnt_busy", {31'd0, CPU_GNT}, 32'd0);
            if (exp_strobe) begin
                check_eq("wr_wen", {31'd0, WEN_after_mux}, 32'd0);
                check_eq("wr_addr", {23'd0, A_after_mux}, {23'd0, a});
                check_eq("wr_data", {24'd0, D_after_mux}, {24'd0, w});
            end
            tick();
        end
        @(negedge CLK);
        check_eq("wr_done_rdy", {31'd0, CTRL_RDY}, 32'd1);
        tick();
        CTRL_SI = 1'b0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input logic [31:0] words);
        logic [DW-1:0] w, got;
        send_start(MODE_RD, addr);
        check_eq("rd_par_clr", {31'd0, PAR_ERR}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            w = words[31 - 8*i -: 8];
            @(negedge CLK);
            check_eq("rd_strobe", {30'd0, CEN_after_mux, WEN_after_mux}, 32'd1);
            check_eq("rd_so_req", {31'd0, CTRL_SO}, 32'd0);
            tick();
            if (i == 0) begin
                @(negedge CLK);
                check_eq("rd_so_cap", {31'd0, CTRL_SO}, 32'd0);
            end
            tick();
            got = '0;
            for (int b = 0; b < DW; b++) begin
                @(negedge CLK);
                got = {got[DW-2:0], CTRL_SO};
                tick();
            end
            check_eq("rd_word", {24'd0, got}, {24'd0, w});
`ifdef SCAN_PARITY_EN
            @(negedge CLK);
            check_eq("rd_parity", {31'd0, CTRL_SO}, {31'd0, ^w});
            tick();
`endif
        end
        @(negedge CLK);
        check_eq("rd_done_rdy", {31'd0, CTRL_RDY}, 32'd1);
        tick();
    endtask

    initial begin
        RST_N     = 1'b0;
        CTRL_MODE = MODE_IDLE;
        CTRL_BGN  = 1'b0;
        CTRL_SI   = 1'b0;
        CPU_CEN   = 1'b1;
        CPU_WEN   = 1'b1;
        CPU_A     = '0;
        CPU_D     = '0;
        #12;
        check_eq("rst_rdy", {31'd0, CTRL_RDY}, 32'd1);
        check_eq("rst_pins", {28'd0, CEN_after_mux, WEN_after_mux, CTRL_SO, CPU_GNT}, 32'hC);
        check_eq("rst_a", {23'd0, A_after_mux}, 32'd0);
        check_eq("rst_d", {24'd0, D_after_mux}, 32'd0);
        check_eq("rst_par", {31'd0, PAR_ERR}, 32'd0);
        RST_N = 1'b1;
        tick();
        tick();

        // Serial write then readback at 0x005.
        wr_burst(9'h005, 32'hA53C5AC3, 4'b0000, 1'b0);
        check_eq("mem_005", {24'd0, mem[9'h005]}, 32'hA5);
        check_eq("mem_006", {24'd0, mem[9'h006]}, 32'h3C);
        rd_burst(9'h005, 32'hA53C5AC3);

        // CPU run mode: grant after one cycle, pins follow the CPU.
        CTRL_MODE = MODE_CPU;
        @(negedge CLK);
        check_eq("gnt_lat", {31'd0, CPU_GNT}, 32'd0);
        tick();
        @(negedge CLK);
        check_eq("gnt_on", {31'd0, CPU_GNT}, 32'd1);
        CPU_CEN = 1'b0;
        CPU_WEN = 1'b0;
        CPU_A   = 9'h010;
        CPU_D   = 8'h77;
        #1;
        check_eq("cpu_pins", {22'd0, CEN_after_mux, A_after_mux}, {22'd0, 1'b0, 9'h010});
        tick();
        CPU_WEN = 1'b1;
        tick();
        @(negedge CLK);
        check_eq("cpu_rd_010", {24'd0, CPU_Q}, 32'h77);
        CPU_A = 9'h006;
        tick();
        @(negedge CLK);
        check_eq("cpu_rd_006", {24'd0, CPU_Q}, 32'h3C);
        CPU_CEN   = 1'b1;
        CTRL_MODE = MODE_IDLE;
        tick();
        @(negedge CLK);
        check_eq("gnt_off", {31'd0, CPU_GNT}, 32'd0);
        tick();

        // Wrapping burst with CPU strobes active and a mid-burst mode change.
        acc0    = acc_cnt;
        CPU_CEN = 1'b0;
        CPU_WEN = 1'b0;
        CPU_A   = 9'h005;
        CPU_D   = 8'hFF;
        wr_burst(9'h1FE, 32'h11223344, 4'b0000, 1'b1);
        CPU_CEN   = 1'b1;
        CPU_WEN   = 1'b1;
        CTRL_MODE = MODE_IDLE;
        check_eq("wrap_acc", acc_cnt - acc0, 32'd4);
        check_eq("cpu_ignored", {24'd0, mem[9'h005]}, 32'hA5);
        check_eq("mem_000", {24'd0, mem[9'h000]}, 32'h33);
        check_eq("mem_001", {24'd0, mem[9'h001]}, 32'h44);
        tick();
        rd_burst(9'h1FE, 32'h11223344);

        // Asynchronous reset in the middle of a data word.
        acc0 = acc_cnt;
        send_start(MODE_WR, 9'h0A0);
        for (int b = 0; b < 3; b++) begin
            CTRL_SI = b[0];
            tick();
        end
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("arst_rdy", {31'd0, CTRL_RDY}, 32'd1);
        check_eq("arst_pins", {28'd0, CEN_after_mux, WEN_after_mux, CTRL_SO, CPU_GNT}, 32'hC);
        check_eq("arst_a", {23'd0, A_after_mux}, 32'd0);
        check_eq("arst_d", {24'd0, D_after_mux}, 32'd0);
        CTRL_MODE = MODE_IDLE;
        CTRL_SI   = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) tick();
        check_eq("arst_no_wr", acc_cnt - acc0, 32'd0);
        check_eq("arst_idle", {31'd0, CTRL_RDY}, 32'd1);

`ifdef SCAN_PARITY_EN
        wr_burst(9'h030, 32'h11223344, 4'b0000, 1'b0);
        check_eq("par_ok_flag", {31'd0, PAR_ERR}, 32'd0);
        acc0 = acc_cnt;
        wr_burst(9'h030, 32'hA5556677, 4'b0001, 1'b0);
        check_eq("par_err_set", {31'd0, PAR_ERR}, 32'd1);
        check_eq("par_acc", acc_cnt - acc0, 32'd3);
        check_eq("par_kept", {24'd0, mem[9'h030]}, 32'h11);
        check_eq("par_next", {24'd0, mem[9'h031]}, 32'h55);
        rd_burst(9'h030, 32'h11556677);
`endif
        check_eq("par_final", {31'd0, PAR_ERR}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_serial_loader_arb.md
Name: sram_serial_loader_arb

Overview:
- Parametrised successor to the fixed 512x8 SRAM muxing in the current top.
- Owns the single-port synchronous SRAM (active-low CEN/WEN).
- Arbitrates between a serial scan loader (CTRL_SI/CTRL_SO, burst write/readback) and the CPU core port.
- Sits between the pad ring / CPU controller and the SRAM macro; generalised in data width, address width and burst length.

Parameters:
- DATA_W, 8, SRAM word width.
- ADDR_W, 9, SRAM address width; depth is 2**ADDR_W.
- BURST_LEN, 16, words per serial transfer; must be 1..2**ADDR_W.

Ports:
- CLK  in  1  single system clock; everything is clocked on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CTRL_MODE  in  2  00 idle, 01 serial write, 10 serial read, 11 CPU run.
- CTRL_BGN  in  1  level; rising edge (sampled) starts a serial transfer.
- CTRL_SI  in  1  serial in, MSB first.
- CTRL_SO  out  1  serial out, MSB first.
- CTRL_RDY  out  1  high when the loader is idle/done.
- CPU_GNT  out  1  CPU owns the SRAM.
- CPU_CEN, CPU_WEN  in  1 each  CPU SRAM strobes, active-low.
- CPU_A  in  ADDR_W  CPU address.
- CPU_D  in  DATA_W  CPU write data.
- CPU_Q  out  DATA_W  SRAM read data, routed back to the CPU.
- CEN_after_mux, WEN_after_mux  out  1 each  to SRAM.
- A_after_mux  out  ADDR_W  to SRAM.
- D_after_mux  out  DATA_W  to SRAM.
- Q_from_SRAM  in  DATA_W  from SRAM; valid the cycle after a read strobe.
- PAR_ERR  out  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset (async, any state, including mid-burst):
  - state=IDLE; CTRL_RDY=1, CTRL_SO=0, CPU_GNT=0, CEN=1, WEN=1, A=0, D=0, PAR_ERR=0.
  - All counters and shift registers are cleared.
- Start condition: CTRL_BGN rise detected with a registered previous value. It is ignored unless state=IDLE and CTRL_MODE is 01 or 10.
- States:
  - IDLE: CTRL_RDY=1. Start with mode 01 or 10 -> SH_ADDR.
  - SH_ADDR: shift ADDR_W bits into addr_reg over ADDR_W cycles.
    - Mode 01 -> SH_DATA.
    - Mode 10 -> RD_REQ.
  - SH_DATA: shift DATA_W bits -> MEM_WR.
  - MEM_WR: one cycle with CEN=0, WEN=0, A=addr_reg, D=data_reg. Then addr+1 and cnt+1.
    - cnt==BURST_LEN -> DONE.
    - Otherwise -> SH_DATA.
  - RD_REQ: one cycle with CEN=0, WEN=1 -> RD_CAP.
  - RD_CAP: load Q_from_SRAM into shift register -> SH_OUT.
  - SH_OUT: DATA_W cycles; CTRL_SO = shreg MSB, shifting left each cycle. Then addr+1 and cnt+1.
    - cnt==BURST_LEN -> DONE.
    - Otherwise -> RD_REQ.
  - DONE: CTRL_RDY=1 for one cycle -> IDLE.
- The serial bit on CTRL_SI is sampled every cycle in the shift states; no gaps are allowed.
- Address increments modulo 2**ADDR_W: the address wraps from all-ones to 0 without error.
- Read latency: first SO bit appears 2 cycles after the last address bit. Per-word period is DATA_W+2 cycles.
- Arbitration:
  - CPU_GNT=1 only when state=IDLE and CTRL_MODE=11, registered (1-cycle latency).
  - While granted, the SRAM pins follow the CPU_* inputs combinationally.
  - When not granted, CEN=1 unless the loader is strobing; CPU strobes are ignored.
- A CTRL_MODE change mid-burst is ignored until DONE; the latched mode governs the burst.
- CPU_Q = Q_from_SRAM at all times.
- CTRL_SO = 0 outside SH_OUT.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Enabled:
  - In write mode, each data word is followed by one even-parity bit, so SH_DATA lasts DATA_W+1 cycles.
  - On mismatch, the MEM_WR strobe is suppressed (CEN stays 1), the address still increments, and PAR_ERR is set sticky until reset or the next start.
  - In read mode, the parity bit is appended after each word on CTRL_SO.
- Disabled: no parity bit; PAR_ERR is tied 0.

Decomposition:
- Shared package: state encoding constants, CTRL_MODE codes (MODE_IDLE/WR/RD/CPU).
- One sub-module: sram_port_mux, combinational selection of loader vs CPU strobes, address and data onto the *_after_mux outputs.

Test Plan:
- Reset, then mode 01, start, address 0x005, data 0xA5, 0x3C, ... (BURST_LEN=2) -> SRAM[5]=0xA5, SRAM[6]=0x3C; CTRL_RDY high one cycle after the second write.
- Mode 10, address 0x005 -> CTRL_SO emits 10100101 then 00111100, first bit 2 cycles after the last address bit.
- Write burst of 4 starting at address 0x1FE -> words land at 0x1FE, 0x1FF, 0x000, 0x001.
- Mode 11 in IDLE -> CPU_GNT=1 next cycle; CPU write 0x77 to 0x010 lands. CPU strobes asserted during a loader burst -> no SRAM access.
- RST_N low mid-SH_DATA -> all outputs at reset values immediately (async); no partial write occurs.
- SCAN_PARITY_EN: send 0xA5 with parity 1 (bad) -> no write, PAR_ERR=1; send with parity 0 -> write occurs.
